// File: rtl/onewire_byte_seq.sv
// Byte-level command sequencer for the onewire bit master: splits reset/write/read byte commands
// into master bit cycles over Avalon MM. Optional CRC8 tracking when ONEWIRE_SEQ_CRC_EN is defined.
module onewire_byte_seq #(
    parameter int ADW = 32,
    parameter int PDL = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [7:0]     cmd_data,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [7:0]     rsp_data,
    output logic           rsp_presence,
    output logic [7:0]     rsp_crc,
    output logic           avalon_read,
    output logic           avalon_write,
    output logic [ADW-1:0] avalon_writedata,
    input  logic [ADW-1:0] avalon_readdata,
    input  logic           avalon_waitrequest
);
    localparam int PCW = (PDL > 1) ? $clog2(PDL) : 1;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_DLY,
        S_POLL,
        S_NXT,
        S_RSP
    } state_t;

    state_t         state_reg, state_next;
    logic [1:0]     op_reg;
    logic [7:0]     shift_reg;
    logic [2:0]     bit_cnt_reg;
    logic [PCW-1:0] poll_cnt_reg;
    logic           cmd_ready_reg;
    logic [7:0]     rsp_data_reg;
    logic           rsp_presence_reg;

    logic accept, wr_xfer, rd_xfer, status_done, status_line, in_bit, poll_last;
    logic unused_readdata;

    assign accept      = cmd_valid & cmd_ready_reg;
    assign wr_xfer     = avalon_write & ~avalon_waitrequest;
    assign rd_xfer     = avalon_read & ~avalon_waitrequest;
    assign status_done = avalon_readdata[4];
    assign status_line = avalon_readdata[0];
    // Read ops shift in the sampled line; write ops recirculate the bit just sent.
    assign in_bit      = (op_reg == OP_READ) ? status_line : shift_reg[0];
    assign poll_last   = (poll_cnt_reg == PCW'(PDL - 1));
    assign unused_readdata = ^{avalon_readdata[ADW-1:5], avalon_readdata[3:1]};

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: if (accept) state_next = (cmd_op == OP_NOP) ? S_RSP : S_WR;
            S_WR:   if (wr_xfer) state_next = S_DLY;
            S_DLY:  if (poll_last) state_next = S_POLL;
            S_POLL: begin
                if (rd_xfer) begin
                    if (!status_done)            state_next = S_DLY;
                    else if (op_reg == OP_RESET) state_next = S_RSP;
                    else                         state_next = S_NXT;
                end
            end
            S_NXT:  state_next = (bit_cnt_reg == 3'd7) ? S_RSP : S_WR;
            S_RSP:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        avalon_writedata = '0;
        if (state_reg == S_WR) begin
            if (op_reg == OP_RESET) avalon_writedata[1] = 1'b1;
            else                    avalon_writedata[0] = (op_reg == OP_READ) ? 1'b1 : shift_reg[0];
        end
    end

    assign avalon_write = (state_reg == S_WR);
    assign avalon_read  = (state_reg == S_POLL);
    assign rsp_valid    = (state_reg == S_RSP);
    assign cmd_ready    = cmd_ready_reg;
    assign rsp_data     = rsp_data_reg;
    assign rsp_presence = rsp_presence_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            op_reg           <= OP_NOP;
            shift_reg        <= '0;
            bit_cnt_reg      <= '0;
            poll_cnt_reg     <= '0;
            cmd_ready_reg    <= 1'b0;
            rsp_data_reg     <= '0;
            rsp_presence_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= (state_next == S_IDLE);
            unique case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg       <= cmd_op;
                        shift_reg    <= cmd_data;
                        bit_cnt_reg  <= '0;
                        poll_cnt_reg <= '0;
                        if (cmd_op == OP_NOP) begin
                            rsp_data_reg     <= '0;
                            rsp_presence_reg <= 1'b0;
                        end
                    end
                end
                S_DLY: poll_cnt_reg <= poll_last ? '0 : poll_cnt_reg + 1'b1;
                S_POLL: begin
                    if (rd_xfer && status_done) begin
                        if (op_reg == OP_RESET) begin
                            rsp_data_reg     <= '0;
                            rsp_presence_reg <= ~status_line;
                        end else begin
                            shift_reg <= {in_bit, shift_reg[7:1]};
                        end
                    end
                end
                S_NXT: begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7) begin
                        rsp_data_reg     <= shift_reg;
                        rsp_presence_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ONEWIRE_SEQ_CRC_EN
    logic [7:0] crc_reg;
    logic [7:0] crc_upd;
    logic [7:0] rsp_crc_reg;

    // Reflected Dallas CRC8 step on the bit that just entered shift_reg[7].
    assign crc_upd = {1'b0, crc_reg[7:1]} ^ ((crc_reg[0] ^ shift_reg[7]) ? 8'h8C : 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_reg     <= '0;
            rsp_crc_reg <= '0;
        end else begin
            if (state_reg == S_NXT)
                crc_reg <= crc_upd;
            else if (state_reg == S_POLL && rd_xfer && status_done && op_reg == OP_RESET)
                crc_reg <= '0;
            if (state_next == S_RSP && state_reg != S_RSP) begin
                if (state_reg == S_NXT)       rsp_crc_reg <= crc_upd;
                else if (state_reg == S_POLL) rsp_crc_reg <= '0;
                else                          rsp_crc_reg <= crc_reg;
            end
        end
    end

    assign rsp_crc = rsp_crc_reg;
`else
    assign rsp_crc = 8'h00;
`endif

endmodule

// File: tb/tb_onewire_byte_seq.sv
// Directed self-checking bench for onewire_byte_seq with a small Avalon slave model of the bit master.
`timescale 1ns/1ps
module tb_onewire_byte_seq;
    localparam int ADW = 32;
    localparam int PDL = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = 2'b11;
    logic [7:0]      cmd_data = 8'h00;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [7:0]      rsp_data;
    logic            rsp_presence;
    logic [7:0]      rsp_crc;
    logic            avalon_read;
    logic            avalon_write;
    logic [ADW-1:0]  avalon_writedata;
    logic [ADW-1:0]  avalon_readdata;
    logic            avalon_waitrequest = 1'b0;

    always #5 clk = ~clk;

    onewire_byte_seq #(.ADW(ADW), .PDL(PDL)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_presence(rsp_presence), .rsp_crc(rsp_crc),
        .avalon_read(avalon_read), .avalon_write(avalon_write),
        .avalon_writedata(avalon_writedata), .avalon_readdata(avalon_readdata),
        .avalon_waitrequest(avalon_waitrequest)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: each write starts a slot; the slot reports busy for busy_cfg polls, then done.
    logic        clr = 1'b1;
    int          busy_cfg = 0;
    logic [7:0]  line_bits = 8'h00;
    int          polls_left, wr_cnt, rd_cnt, slot_idx, gap_bad, last_rd_cyc;
    int          both_high = 0;
    logic        pending_gap;
    logic        line_val;
    logic [31:0] wr_log [0:15];

    assign avalon_readdata = (polls_left > 0) ? 32'h0 : {27'd0, 1'b1, 3'd0, line_val};

    always @(posedge clk) begin
        if (avalon_read && avalon_write) both_high <= both_high + 1;
        if (clr) begin
            polls_left  <= 0;
            wr_cnt      <= 0;
            rd_cnt      <= 0;
            slot_idx    <= 0;
            gap_bad     <= 0;
            last_rd_cyc <= 0;
            pending_gap <= 1'b0;
            line_val    <= 1'b0;
        end else begin
            if (avalon_write && !avalon_waitrequest) begin
                if (wr_cnt < 16) wr_log[wr_cnt] <= avalon_writedata;
                wr_cnt      <= wr_cnt + 1;
                polls_left  <= busy_cfg;
                line_val    <= line_bits[slot_idx % 8];
                slot_idx    <= slot_idx + 1;
                pending_gap <= 1'b0;
            end
            if (avalon_read && !avalon_waitrequest) begin
                rd_cnt      <= rd_cnt + 1;
                last_rd_cyc <= cyc;
                pending_gap <= (polls_left > 0);
                if (pending_gap && (cyc - last_rd_cyc) != PDL + 1) gap_bad <= gap_bad + 1;
                if (polls_left > 0) polls_left <= polls_left - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_data  = 8'h00;
        if (op != 2'b11) chk("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk("rsp_valid_seen", rsp_valid, 1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("cmd_ready_return", cmd_ready, 1);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [7:0] data, output int lat);
        model_clear();
        send_cmd(op, data);
        wait_rsp(lat);
    endtask

    task automatic check_writes(input logic [7:0] byte_v, input logic read_op);
        logic [31:0] exp;
        chk("write_count", wr_cnt, 8);
        for (int i = 0; i < 8; i++) begin
            exp = read_op ? 32'h1 : {31'd0, byte_v[i]};
            chk("write_slot", wr_log[i], exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;
        logic [7:0] held;
        logic [7:0] crc_bytes [0:6];
        crc_bytes[0] = 8'h02; crc_bytes[1] = 8'h1C; crc_bytes[2] = 8'hB8; crc_bytes[3] = 8'h01;
        crc_bytes[4] = 8'h00; crc_bytes[5] = 8'h00; crc_bytes[6] = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_presence", rsp_presence, 0);
        chk("rst_rsp_crc", rsp_crc, 0);
        chk("rst_av_read", avalon_read, 0);
        chk("rst_av_write", avalon_write, 0);
        chk("rst_av_wdata", avalon_writedata, 0);
        rst = 1'b0;
        clr = 1'b0;
        tick();
        chk("cmd_ready_after_rst", cmd_ready, 1);

        // Reset op, slave present
        line_bits = 8'h00;
        do_op(2'b00, 8'h77, lat);
        chk("reset_presence", rsp_presence, 1);
        chk("reset_data", rsp_data, 8'h00);
        chk("reset_wr_count", wr_cnt, 1);
        chk("reset_wr_value", wr_log[0], 32'h2);
        chk("reset_rd_count", rd_cnt, 1);
        take_rsp();

        // Reset op, no slave
        line_bits = 8'hFF;
        do_op(2'b00, 8'h00, lat);
        chk("reset_absent", rsp_presence, 0);
        take_rsp();

        // Write 0xA5, minimum latency; line model returns the inverse to catch wrong bit source
        line_bits = 8'h5A;
        do_op(2'b01, 8'hA5, lat);
        chk("write_latency", lat, 88);
        chk("write_data", rsp_data, 8'hA5);
        chk("write_presence", rsp_presence, 0);
        check_writes(8'hA5, 1'b0);
        take_rsp();

        // Read byte: sampled sequence 0,1,1,0,0,1,0,0
        line_bits = 8'h26;
        do_op(2'b10, 8'hFF, lat);
        chk("read_data", rsp_data, 8'h26);
        check_writes(8'h00, 1'b1);
        take_rsp();

        // Busy polls: 3 not-done polls per bit
        busy_cfg = 3;
        do_op(2'b01, 8'h3C, lat);
        chk("busy_data", rsp_data, 8'h3C);
        chk("busy_rd_count", rd_cnt, 32);
        chk("busy_poll_gap", gap_bad, 0);
        take_rsp();
        busy_cfg = 0;

        // Waitrequest stall: request held stable
        avalon_waitrequest = 1'b1;
        model_clear();
        send_cmd(2'b01, 8'h81);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (avalon_write !== 1'b1 || avalon_writedata !== 32'h1 || avalon_read !== 1'b0) bad++;
            tick();
        end
        chk("stall_hold", bad, 0);
        avalon_waitrequest = 1'b0;
        wait_rsp(lat);
        chk("stall_data", rsp_data, 8'h81);
        chk("stall_wr_count", wr_cnt, 8);

        // Response held while rsp_ready low
        held = rsp_data;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== held) bad++;
        end
        chk("rsp_hold", bad, 0);
        take_rsp();

        // rst during bit 4 of a write
        model_clear();
        send_cmd(2'b01, 8'h5A);
        lat = 0;
        while (wr_cnt < 5 && lat < 500) begin
            tick();
            lat++;
        end
        chk("abort_reached_bit4", wr_cnt, 5);
        rst = 1'b1;
        tick();
        chk("abort_av_write", avalon_write, 0);
        chk("abort_av_read", avalon_read, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        tick();
        chk("abort_cmd_ready", cmd_ready, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b0) bad++;
            tick();
        end
        chk("abort_no_rsp", bad, 0);

        // No-op: no Avalon traffic
        do_op(2'b11, 8'hEE, lat);
        chk("nop_data", rsp_data, 0);
        chk("nop_presence", rsp_presence, 0);
        chk("nop_wr_count", wr_cnt, 0);
        take_rsp();

        // CRC sequence
        line_bits = 8'h00;
        do_op(2'b00, 8'h00, lat);
        chk("crc_after_reset", rsp_crc, 0);
        take_rsp();
        for (int k = 0; k < 7; k++) begin
            do_op(2'b01, crc_bytes[k], lat);
            chk("crc_seq_data", rsp_data, {24'd0, crc_bytes[k]});
`ifdef ONEWIRE_SEQ_CRC_EN
            if (k == 0) chk("crc_first_byte", rsp_crc, 8'hBC);
            if (k == 6) chk("crc_rom", rsp_crc, 8'hA2);
`else
            if (k == 6) chk("crc_tied", rsp_crc, 8'h00);
`endif
            take_rsp();
        end
        do_op(2'b01, 8'hA2, lat);
        chk("crc_residue_data", rsp_data, 8'hA2);
        chk("crc_residue", rsp_crc, 8'h00);
        take_rsp();

        chk("never_both_high", both_high, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
